rs_issue_queue: RTL
===================

RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

Interface
REQ-001 Parameter N_ENT, default 8, number of reservation-station entries; power of two, 2..16.
REQ-002 Parameter TAG_W, default 6, physical-register tag width.
REQ-003 Parameter PAY_W, default 32, opaque instruction payload width (opcode, immediate, ROB index).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 squash  input  1  synchronous flush of all entries and the issue register.
REQ-007 disp_valid  input  1  dispatch request this cycle.
REQ-008 disp_dest  input  TAG_W  destination tag of the dispatched instruction.
REQ-009 disp_src1, disp_src2  input  TAG_W each  source tags.
REQ-010 disp_rdy1, disp_rdy2  input  1 each  source value already available.
REQ-011 disp_pay  input  PAY_W  payload.
REQ-012 full  output  1  no free entry; dispatch is ignored while high.
REQ-013 cdb_valid  input  1  completion broadcast valid.
REQ-014 cdb_tag  input  TAG_W  broadcast destination tag.
REQ-015 iss_valid  output  1  issue register holds an instruction for the functional unit.
REQ-016 iss_ready  input  1  functional unit accepts; transfer occurs when iss_valid and iss_ready are both high.
REQ-017 iss_dest, iss_src1, iss_src2, iss_pay  output  TAG_W/TAG_W/TAG_W/PAY_W  issued instruction fields.

Function
REQ-018 Each entry holds valid, dest, src1, src2, rdy1, rdy2 and payload; entry ready = valid & rdy1 & rdy2.
REQ-019 full is combinational from registered state only: high when every entry is valid.
REQ-020 When disp_valid is high and full is low, the instruction is written into the highest-index free entry at the clock edge.
REQ-021 Wakeup: at each edge with cdb_valid, every valid entry with src1 == cdb_tag sets rdy1, and every valid entry with src2 == cdb_tag sets rdy2.
REQ-022 Dispatch/CDB bypass: if cdb_valid and cdb_tag equals disp_src1 (or disp_src2) in the dispatch cycle, the written rdy1 (or rdy2) is 1.
REQ-023 Select: among ready entries, the highest-index entry is chosen (fixed priority, bit N_ENT-1 highest), so that the grant is one-hot or all-zero.
REQ-024 The issue register may load when it is empty or being drained this cycle (load_ok = !iss_valid | iss_ready).
REQ-025 When load_ok holds and a ready entry exists, the selected entry is copied to the issue register and its valid bit is cleared at the same edge; iss_valid is 1 next cycle.
REQ-026 When load_ok holds and no entry is ready, iss_valid becomes 0 at the edge.
REQ-027 While iss_valid & !iss_ready, all iss_* outputs hold stable and no entry is issued.
REQ-028 Latency: an instruction dispatched ready at edge E (or woken at E) appears on iss_* after edge E+1 at the earliest; no zero-cycle issue.
REQ-029 An entry freed by issue at edge E is not usable by a dispatch at the same edge E, because full uses pre-edge state.
REQ-030 squash clears all entry valid bits and iss_valid at the edge and takes priority over dispatch, wakeup and issue in that cycle.
REQ-031 At most one dispatch, one wakeup tag and one issue occur per cycle; order-independent within a cycle.

Reset
REQ-032 While reset_n is low: all entry valid and ready bits are 0, iss_valid=0, full=0, iss_dest/src1/src2/pay=0.
REQ-033 Reset assertion mid-operation clears state immediately, without waiting for clock; the first dispatch is accepted at the first edge after reset_n rises.

Verification
REQ-034 Dispatch dest=5,src1=1,src2=2,rdy1=rdy2=1, iss_ready=1 -> iss_valid=1, iss_dest=5 two edges later, then entry free.
REQ-035 Dispatch rdy1=0 src1=9; cdb_tag=9 valid three cycles later -> iss_valid rises two edges after the CDB edge; same-cycle dispatch with cdb_tag=9 -> issue as if ready.
REQ-036 Fill 8 entries with unready sources -> full=1; ninth dispatch ignored; wake entry 7 and let it issue -> full=0 the cycle after issue.
REQ-037 Entries 2 and 6 ready together, iss_ready=0 for 3 cycles -> iss_dest holds entry 6 stable; entry 2 issues the cycle after iss_ready rises.
REQ-038 squash with 4 valid entries and iss_valid=1 -> all cleared, full=0, iss_valid=0 next cycle; concurrent dispatch dropped.
REQ-039 reset_n pulsed low between edges with entries valid -> iss_valid=0, full=0 immediately; no stale issue afterwards.

Source files
------------

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation-station issue queue with CDB wakeup and fixed-priority select
module rs_issue_queue #(
    parameter int N_ENT = 8,
    parameter int TAG_W = 6,
    parameter int PAY_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             squash,
    input  logic             disp_valid,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic [TAG_W-1:0] disp_src1,
    input  logic [TAG_W-1:0] disp_src2,
    input  logic             disp_rdy1,
    input  logic             disp_rdy2,
    input  logic [PAY_W-1:0] disp_pay,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [TAG_W-1:0] iss_dest,
    output logic [TAG_W-1:0] iss_src1,
    output logic [TAG_W-1:0] iss_src2,
    output logic [PAY_W-1:0] iss_pay
);
    localparam int IDX_W = $clog2(N_ENT);

    logic [N_ENT-1:0] ent_valid;
    logic [N_ENT-1:0] ent_rdy1;
    logic [N_ENT-1:0] ent_rdy2;
    logic [TAG_W-1:0] ent_dest [N_ENT];
    logic [TAG_W-1:0] ent_src1 [N_ENT];
    logic [TAG_W-1:0] ent_src2 [N_ENT];
    logic [PAY_W-1:0] ent_pay  [N_ENT];

    logic [N_ENT-1:0] ent_ready;
    logic [N_ENT-1:0] grant;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             load_ok;
    logic             do_issue;
    logic             do_disp;
    logic             byp1;
    logic             byp2;

    assign ent_ready = ent_valid & ent_rdy1 & ent_rdy2;
    assign sel_any   = |ent_ready;
    assign full      = &ent_valid;
    assign load_ok   = !iss_valid || iss_ready;
    assign do_issue  = load_ok && sel_any;
    assign do_disp   = disp_valid && !full;
    assign byp1      = cdb_valid && (cdb_tag == disp_src1);
    assign byp2      = cdb_valid && (cdb_tag == disp_src2);

    // Ascending scan: the last hit wins, giving highest-index priority for both searches.
    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (!ent_valid[i]) alloc_idx = IDX_W'(i);
            if (ent_ready[i])  sel_idx   = IDX_W'(i);
        end
        grant = '0;
        if (sel_any) grant[sel_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid <= '0;
            ent_rdy1  <= '0;
            ent_rdy2  <= '0;
        end else if (squash) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                if (cdb_valid && ent_valid[i] && ent_src1[i] == cdb_tag) ent_rdy1[i] <= 1'b1;
                if (cdb_valid && ent_valid[i] && ent_src2[i] == cdb_tag) ent_rdy2[i] <= 1'b1;
            end
            // The allocated entry is invalid pre-edge, so it never collides with the granted one.
            if (do_issue) ent_valid <= ent_valid & ~grant;
            if (do_disp) begin
                ent_valid[alloc_idx] <= 1'b1;
                ent_rdy1[alloc_idx]  <= disp_rdy1 || byp1;
                ent_rdy2[alloc_idx]  <= disp_rdy2 || byp2;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_disp && !squash) begin
            ent_dest[alloc_idx] <= disp_dest;
            ent_src1[alloc_idx] <= disp_src1;
            ent_src2[alloc_idx] <= disp_src2;
            ent_pay[alloc_idx]  <= disp_pay;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid <= 1'b0;
            iss_dest  <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_pay   <= '0;
        end else if (squash) begin
            iss_valid <= 1'b0;
        end else if (load_ok) begin
            iss_valid <= sel_any;
            if (sel_any) begin
                iss_dest <= ent_dest[sel_idx];
                iss_src1 <= ent_src1[sel_idx];
                iss_src2 <= ent_src2[sel_idx];
                iss_pay  <= ent_pay[sel_idx];
            end
        end
    end
endmodule
